// File: rtl/ex_mem_stage.sv
// EX/MEM latch, data-memory access controller and MEM/WB latch.
// Stalls the upstream pipeline while a load/store is outstanding and exposes
// the EM and MW values used by the execute-stage forwarding muxes.
module ex_mem_stage #(
    parameter int unsigned DW = 16,
    parameter int unsigned RW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic [DW-1:0] ex_result,
    input  logic [DW-1:0] ex_store_data,
    input  logic [RW-1:0] ex_wreg,
    input  logic          ex_regwrite,
    input  logic          ex_memread,
    input  logic          ex_memwrite,
    input  logic          ex_halt,
    output logic          stall_up,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic          mem_busy,
    input  logic          mem_done,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] PipeEM_Result,
    output logic [RW-1:0] em_wreg,
    output logic          em_regwrite,
    output logic          em_memread,
    output logic [DW-1:0] PipeMW_Result,
    output logic [RW-1:0] wb_wreg,
    output logic          wb_regwrite,
    output logic          wb_halt,
    output logic          Err
);

    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_em_valid;
    logic [DW-1:0] r_em_result;
    logic [DW-1:0] r_em_store_data;
    logic [RW-1:0] r_em_wreg;
    logic          r_em_regwrite;
    logic          r_em_memread;
    logic          r_em_memwrite;
    logic          r_em_halt;

    logic [DW-1:0] r_mw_result;
    logic [RW-1:0] r_wb_wreg;
    logic          r_wb_regwrite;
    logic          r_wb_halt;

    logic          r_err;
    logic          r_halted;

    logic          w_mem_op;
    logic          w_misalign;
    logic          w_halt_em;
    logic          w_stall;
    logic          w_complete;
    logic          w_rd;
    logic          w_wr;

    assign w_mem_op   = r_em_valid & (r_em_memread | r_em_memwrite);
    assign w_misalign = w_mem_op & r_em_result[0];
    assign w_halt_em  = r_em_valid & r_em_halt;

    // Access control: request generation, stall and completion decode
    always_comb begin
        w_stall     = 1'b0;
        w_complete  = 1'b0;
        w_rd        = 1'b0;
        w_wr        = 1'b0;
        w_state_nxt = r_state;
        if (r_halted) begin
            w_stall = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_op && !w_misalign) begin
                        w_rd = r_em_memread;
                        w_wr = r_em_memwrite & ~r_em_memread;
                        if (mem_busy) begin
                            w_stall = 1'b1;
                        end else if (mem_done) begin
                            w_complete = 1'b1;
                        end else begin
                            w_stall     = 1'b1;
                            w_state_nxt = ST_WAIT;
                        end
                    end else begin
                        // Misaligned ops retire as bubbles
                        w_complete = r_em_valid & ~w_misalign;
                    end
                end
                ST_WAIT: begin
                    w_stall = 1'b1;
                    if (mem_done) begin
                        w_stall     = 1'b0;
                        w_complete  = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    // FSM state, sticky error and halt flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_RUN;
            r_err    <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_misalign) r_err <= 1'b1;
            if (w_halt_em)  r_halted <= 1'b1;
        end
    end

    // EM latch: loads when not stalled; nothing behind a halt is admitted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_em_valid      <= 1'b0;
            r_em_result     <= '0;
            r_em_store_data <= '0;
            r_em_wreg       <= '0;
            r_em_regwrite   <= 1'b0;
            r_em_memread    <= 1'b0;
            r_em_memwrite   <= 1'b0;
            r_em_halt       <= 1'b0;
        end else if (!w_stall) begin
            r_em_valid      <= ex_valid & ~w_halt_em;
            r_em_result     <= ex_result;
            r_em_store_data <= ex_store_data;
            r_em_wreg       <= ex_wreg;
            r_em_regwrite   <= ex_regwrite;
            r_em_memread    <= ex_memread;
            r_em_memwrite   <= ex_memwrite;
            r_em_halt       <= ex_halt;
        end
    end

    // MW latch: captures the EM op on completion, a bubble otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mw_result   <= '0;
            r_wb_wreg     <= '0;
            r_wb_regwrite <= 1'b0;
            r_wb_halt     <= 1'b0;
        end else begin
            r_wb_regwrite <= w_complete & r_em_regwrite;
            if (w_complete) begin
                r_mw_result <= r_em_memread ? mem_rdata : r_em_result;
                r_wb_wreg   <= r_em_wreg;
            end
            if (w_complete && r_em_halt) r_wb_halt <= 1'b1;
        end
    end

    assign stall_up      = w_stall;
    assign mem_rd        = w_rd;
    assign mem_wr        = w_wr;
    assign mem_addr      = r_em_result;
    assign mem_wdata     = r_em_store_data;
    assign PipeEM_Result = r_em_result;
    assign em_wreg       = r_em_wreg;
    assign em_regwrite   = r_em_valid & r_em_regwrite;
    assign em_memread    = r_em_valid & r_em_memread;
    assign PipeMW_Result = r_mw_result;
    assign wb_wreg       = r_wb_wreg;
    assign wb_regwrite   = r_wb_regwrite;
    assign wb_halt       = r_wb_halt;
    assign Err           = r_err;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: expected writebacks and memory requests
// are queued by the stimulus and popped by independent monitors.
module tb_ex_mem_stage;

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_valid;
    logic [DW-1:0] ex_result;
    logic [DW-1:0] ex_store_data;
    logic [RW-1:0] ex_wreg;
    logic          ex_regwrite;
    logic          ex_memread;
    logic          ex_memwrite;
    logic          ex_halt;
    logic          stall_up;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd;
    logic          mem_wr;
    logic          mem_busy;
    logic          mem_done;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] PipeEM_Result;
    logic [RW-1:0] em_wreg;
    logic          em_regwrite;
    logic          em_memread;
    logic [DW-1:0] PipeMW_Result;
    logic [RW-1:0] wb_wreg;
    logic          wb_regwrite;
    logic          wb_halt;
    logic          Err;

    ex_mem_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_result(ex_result), .ex_store_data(ex_store_data),
        .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_halt(ex_halt),
        .stall_up(stall_up), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_busy(mem_busy),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .PipeEM_Result(PipeEM_Result), .em_wreg(em_wreg),
        .em_regwrite(em_regwrite), .em_memread(em_memread),
        .PipeMW_Result(PipeMW_Result), .wb_wreg(wb_wreg),
        .wb_regwrite(wb_regwrite), .wb_halt(wb_halt), .Err(Err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [RW+DW-1:0] wb_q[$];
    logic [2*DW+1:0]  req_q[$];
    logic [RW+DW-1:0] wb_e;
    logic [2*DW+1:0]  req_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Writeback monitor
    always @(negedge clk) begin
        if (rst && wb_regwrite) begin
            if (wb_q.size() == 0) begin
                n_total++;
                $display("FAIL wb_unexpected: got r%0d=0x%0h expected no writeback", wb_wreg, PipeMW_Result);
            end else begin
                wb_e = wb_q.pop_front();
                chk("wb_wreg", 32'(wb_wreg), 32'(wb_e[RW+DW-1:DW]));
                chk("wb_data", 32'(PipeMW_Result), 32'(wb_e[DW-1:0]));
            end
        end
    end

    // Memory request monitor
    always @(negedge clk) begin
        if (rst && (mem_rd || mem_wr)) begin
            chk("req_exclusive", 32'(mem_rd & mem_wr), 32'd0);
            if (req_q.size() == 0) begin
                n_total++;
                $display("FAIL req_unexpected: got rd=%0b wr=%0b addr=0x%0h expected no request", mem_rd, mem_wr, mem_addr);
            end else begin
                req_e = req_q.pop_front();
                chk("req_rdwr", 32'({mem_rd, mem_wr}), 32'(req_e[2*DW+1:2*DW]));
                chk("req_addr", 32'(mem_addr), 32'(req_e[2*DW-1:DW]));
                chk("req_wdata", 32'(mem_wdata), 32'(req_e[DW-1:0]));
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic ex_in(input logic v, input logic [DW-1:0] res, input logic [DW-1:0] sd,
                         input logic [RW-1:0] wr, input logic rw, input logic mr,
                         input logic mw, input logic h);
        ex_valid = v; ex_result = res; ex_store_data = sd; ex_wreg = wr;
        ex_regwrite = rw; ex_memread = mr; ex_memwrite = mw; ex_halt = h;
    endtask

    task automatic ex_idle();
        ex_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic mem_in(input logic b, input logic d, input logic [DW-1:0] rd);
        mem_busy = b; mem_done = d; mem_rdata = rd;
    endtask

    initial begin
        rst = 1'b0;
        ex_idle();
        mem_in(1'b0, 1'b0, '0);
        repeat (2) next();
        smp();
        chk("rst_stall", 32'(stall_up), 0);
        chk("rst_em_regwrite", 32'(em_regwrite), 0);
        chk("rst_em_result", 32'(PipeEM_Result), 0);
        chk("rst_wb_regwrite", 32'(wb_regwrite), 0);
        chk("rst_mw_result", 32'(PipeMW_Result), 0);
        chk("rst_wb_halt", 32'(wb_halt), 0);
        chk("rst_err", 32'(Err), 0);
        chk("rst_mem_rd", 32'(mem_rd), 0);
        next();
        rst = 1'b1;

        // ALU op, no memory traffic
        next();
        ex_in(1'b1, 16'h1234, 16'h0000, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        wb_q.push_back({3'd3, 16'h1234});
        smp();
        chk("t1_stall_c0", 32'(stall_up), 0);
        next();
        ex_idle();
        smp();
        chk("t1_em_result", 32'(PipeEM_Result), 32'h1234);
        chk("t1_em_wreg", 32'(em_wreg), 3);
        chk("t1_em_regwrite", 32'(em_regwrite), 1);
        chk("t1_em_memread", 32'(em_memread), 0);
        chk("t1_wb_early", 32'(wb_regwrite), 0);
        chk("t1_stall_c1", 32'(stall_up), 0);
        next();
        smp();
        chk("t1_wb_regwrite", 32'(wb_regwrite), 1);
        chk("t1_stall_c2", 32'(stall_up), 0);

        // Load completing in its request cycle
        next();
        ex_in(1'b1, 16'h0040, 16'h0000, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        smp();
        chk("t2_stall_c0", 32'(stall_up), 0);
        next();
        ex_idle();
        mem_in(1'b0, 1'b1, 16'hBEEF);
        req_q.push_back({1'b1, 1'b0, 16'h0040, 16'h0000});
        wb_q.push_back({3'd5, 16'hBEEF});
        smp();
        chk("t2_em_memread", 32'(em_memread), 1);
        chk("t2_stall_c1", 32'(stall_up), 0);
        chk("t2_mem_rd", 32'(mem_rd), 1);
        next();
        mem_in(1'b0, 1'b0, 16'h0000);
        smp();
        chk("t2_mem_rd_off", 32'(mem_rd), 0);
        chk("t2_wb_regwrite", 32'(wb_regwrite), 1);
        chk("t2_wb_data", 32'(PipeMW_Result), 32'hBEEF);

        // Store: busy 2 cycles, accepted, done 3 cycles later; an ALU op waits in EX
        next();
        ex_in(1'b1, 16'h0010, 16'h00AA, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        smp();
        chk("t3_stall_c0", 32'(stall_up), 0);
        next();
        ex_in(1'b1, 16'h5555, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        wb_q.push_back({3'd2, 16'h5555});
        for (int i = 0; i < 5; i++) begin
            mem_in(logic'(i < 2), 1'b0, 16'h0000);
            if (i < 3) req_q.push_back({1'b0, 1'b1, 16'h0010, 16'h00AA});
            smp();
            chk("t3_stall", 32'(stall_up), 1);
            chk("t3_em_hold", 32'(PipeEM_Result), 32'h0010);
            chk("t3_mw_bubble", 32'(wb_regwrite), 0);
            chk("t3_mem_wr", 32'(mem_wr), 32'(i < 3));
            next();
        end
        mem_in(1'b0, 1'b1, 16'h0000);
        smp();
        chk("t3_stall_done", 32'(stall_up), 0);
        chk("t3_mem_wr_wait", 32'(mem_wr), 0);
        next();
        mem_in(1'b0, 1'b0, 16'h0000);
        ex_idle();
        smp();
        chk("t3_store_retire", 32'(wb_regwrite), 0);
        chk("t3_em_next", 32'(PipeEM_Result), 32'h5555);
        next();
        smp();
        chk("t3_alu_retire", 32'(wb_regwrite), 1);

        // Misaligned load followed by an ALU op
        next();
        ex_in(1'b1, 16'h0021, 16'h0000, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        smp();
        chk("t4_err_c0", 32'(Err), 0);
        next();
        ex_in(1'b1, 16'h0777, 16'h0000, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        wb_q.push_back({3'd6, 16'h0777});
        smp();
        chk("t4_no_rd", 32'(mem_rd), 0);
        chk("t4_stall", 32'(stall_up), 0);
        chk("t4_err_c1", 32'(Err), 0);
        next();
        ex_idle();
        smp();
        chk("t4_err_set", 32'(Err), 1);
        chk("t4_bubble", 32'(wb_regwrite), 0);
        chk("t4_em_next", 32'(PipeEM_Result), 32'h0777);
        next();
        smp();
        chk("t4_alu_retire", 32'(wb_regwrite), 1);
        for (int i = 0; i < 2; i++) begin
            next();
            smp();
            chk("t4_err_sticky", 32'(Err), 1);
        end

        // Halt followed by an ALU op
        next();
        ex_in(1'b1, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        smp();
        chk("t5_stall_c0", 32'(stall_up), 0);
        chk("t5_wb_halt_c0", 32'(wb_halt), 0);
        next();
        ex_in(1'b1, 16'h0999, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        smp();
        chk("t5_stall_c1", 32'(stall_up), 0);
        chk("t5_wb_halt_c1", 32'(wb_halt), 0);
        next();
        smp();
        chk("t5_wb_halt_c2", 32'(wb_halt), 1);
        chk("t5_stall_c2", 32'(stall_up), 1);
        chk("t5_add_blocked", 32'(em_regwrite), 0);
        for (int i = 0; i < 3; i++) begin
            next();
            smp();
            chk("t5_stall_hold", 32'(stall_up), 1);
            chk("t5_wb_halt_hold", 32'(wb_halt), 1);
            chk("t5_no_wb", 32'(wb_regwrite), 0);
        end
        ex_idle();

        // Reset clears the halt
        next();
        rst = 1'b0;
        smp();
        chk("rst2_wb_halt", 32'(wb_halt), 0);
        chk("rst2_stall", 32'(stall_up), 0);
        next();
        rst = 1'b1;

        // Reset during WAIT drops the access
        next();
        ex_in(1'b1, 16'h0060, 16'h0000, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        smp();
        next();
        ex_idle();
        mem_in(1'b0, 1'b0, 16'h0000);
        req_q.push_back({1'b1, 1'b0, 16'h0060, 16'h0000});
        smp();
        chk("t6_stall_req", 32'(stall_up), 1);
        chk("t6_mem_rd", 32'(mem_rd), 1);
        next();
        smp();
        chk("t6_stall_wait", 32'(stall_up), 1);
        chk("t6_no_rd_wait", 32'(mem_rd), 0);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_stall", 32'(stall_up), 0);
        chk("t6_rst_mem_rd", 32'(mem_rd), 0);
        chk("t6_rst_mem_wr", 32'(mem_wr), 0);
        chk("t6_rst_em_memread", 32'(em_memread), 0);
        chk("t6_rst_em_result", 32'(PipeEM_Result), 0);
        chk("t6_rst_em_wreg", 32'(em_wreg), 0);
        chk("t6_rst_wb_regwrite", 32'(wb_regwrite), 0);
        chk("t6_rst_mw_result", 32'(PipeMW_Result), 0);
        chk("t6_rst_err", 32'(Err), 0);
        next();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next();
            smp();
            chk("t6_no_retry", 32'(mem_rd), 0);
            chk("t6_idle_stall", 32'(stall_up), 0);
        end
        next();
        ex_in(1'b1, 16'h0080, 16'h0000, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        smp();
        next();
        ex_idle();
        mem_in(1'b0, 1'b1, 16'h1357);
        req_q.push_back({1'b1, 1'b0, 16'h0080, 16'h0000});
        wb_q.push_back({3'd3, 16'h1357});
        smp();
        chk("t6_new_stall", 32'(stall_up), 0);
        chk("t6_new_rd", 32'(mem_rd), 1);
        next();
        mem_in(1'b0, 1'b0, 16'h0000);
        smp();
        chk("t6_new_wb", 32'(wb_regwrite), 1);
        next();
        smp();
        chk("wb_q_drained", 32'(wb_q.size()), 0);
        chk("req_q_drained", 32'(req_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline latch, data-memory access controller and MEM/WB latch, placed directly downstream of the execute stage.
- Captures the execute stage's Result, store data and control signals.
- Runs loads and stores against a multi-cycle, stallable data memory and stalls the upstream pipeline while an access is outstanding.
- Returns the EM-stage and MW-stage values that the execute stage's operand-forwarding muxes select (PipeEM_Result, PipeMW_Result).

Parameters:
- DW, 16, data/address width
- RW, 3, register-specifier width

Ports:
- clk  in  1  single clock, all state on the rising edge
- rst  in  1  asynchronous active-low reset
- ex_valid  in  1  execute stage presents a real instruction
- ex_result  in  DW  ALU/set/btr result (memory address for loads and stores)
- ex_store_data  in  DW  store data (forwarded ALUOp2)
- ex_wreg  in  RW  destination register
- ex_regwrite  in  1  writes the register file
- ex_memread  in  1  load
- ex_memwrite  in  1  store
- ex_halt  in  1  halt instruction
- stall_up  out  1  holds EX and earlier stages this cycle
- mem_addr  out  DW  data-memory address
- mem_wdata  out  DW  data-memory write data
- mem_rd  out  1  read request
- mem_wr  out  1  write request
- mem_busy  in  1  request not accepted this cycle, reissue
- mem_done  in  1  access complete (read data valid)
- mem_rdata  in  DW  read data
- PipeEM_Result  out  DW  EM-latched result, forwarding source
- em_wreg  out  RW  EM destination register
- em_regwrite  out  1  EM valid & regwrite
- em_memread  out  1  EM holds a valid load (hazard unit must stall dependants)
- PipeMW_Result  out  DW  writeback data, forwarding source
- wb_wreg  out  RW  writeback register
- wb_regwrite  out  1  writeback enable
- wb_halt  out  1  halt has reached writeback
- Err  out  1  misaligned access, sticky

Behaviour:
Reset (rst=0, asynchronous):
- All EM and MW valids clear; all registered outputs 0; FSM goes to RUN; Err=0; halted=0.
- Reset mid-access drops the access; no retry after reset.

EM latch:
- Loads all ex_* fields at the clock edge when stall_up=0.
- Holds when stall_up=1.

FSM state RUN:
- If EM holds a valid aligned memory op: drive mem_rd or mem_wr with mem_addr=EM result and mem_wdata=EM store data.
  - mem_busy=1: stall_up=1, stay RUN, reissue next cycle.
  - mem_busy=0 and mem_done=1: the op completes this cycle and stall_up=0.
  - mem_busy=0 and mem_done=0: go to WAIT with stall_up=1.
- Non-memory op or bubble: stall_up=0.

FSM state WAIT:
- mem_rd and mem_wr are 0; stall_up=1.
- On mem_done: the op completes, stall_up=0 in that same cycle, go to RUN.

Completion:
- At the edge ending the completing cycle, MW captures the EM op. Data is mem_rdata for loads, EM result otherwise.
- During stall cycles MW captures a bubble (wb_regwrite=0), so each instruction writes back exactly once.

Latency:
- A non-memory op presented in EX at cycle n drives wb_* at cycle n+2.
- A memory op whose done arrives k cycles after acceptance adds k stall cycles.

Misaligned access:
- A memory op with EM result bit0=1 issues no request.
- Err sets and remains 1 until reset.
- The op retires as a bubble with regwrite suppressed.

Halt:
- A valid halt in EM sets halted.
- stall_up stays 1 from the next cycle until reset.
- wb_halt=1 one cycle later and holds.
- No further instruction enters.

Forwarding outputs:
- PipeEM_Result, em_wreg and em_regwrite come directly from the EM latch.
- PipeMW_Result, wb_wreg and wb_regwrite come directly from the MW latch.
- A valid load in EM must raise em_memread.

Request rules:
- mem_rd and mem_wr are never both 1.
- No request is driven from WAIT or on a bubble.

Test Plan:
- Add result 0x1234 to r3 in EX at cycle 0, no memory traffic -> PipeEM_Result=0x1234 at cycle 1; wb_regwrite=1, wb_wreg=3, PipeMW_Result=0x1234 at cycle 2; stall_up never 1.
- Load addr 0x0040 with mem_done in the request cycle -> one mem_rd pulse with mem_addr=0x0040; no stall; PipeMW_Result=mem_rdata=0xBEEF next cycle.
- Store addr 0x0010 data 0x00AA, mem_busy=1 for 2 cycles then accepted, done 3 cycles later -> mem_wr high for 3 cycles; stall_up high 5 cycles; EM holds; MW shows bubbles; wb_regwrite=0 at retire.
- Load at 0x0021 -> no mem_rd; Err=1 and sticky; wb_regwrite=0; the following ALU op retires normally.
- Halt followed by add -> wb_halt=1 two cycles after halt enters EX; add never reaches MW; stall_up stays 1.
- rst pulled low during WAIT -> all outputs 0 immediately; after release a new load issues cleanly from RUN.
